// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch queue
package fetch_pkg;
   localparam int PC_W   = 32;
   localparam int INST_W = 32;

   typedef logic [PC_W-1:0]   pc_t;
   typedef logic [INST_W-1:0] inst_t;

   localparam pc_t HALT_PC = '1;

   typedef struct packed {
      pc_t   pc;
      inst_t inst;
      logic  filled;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_tag_queue.sv
// rtl/fetch_tag_queue.sv - circular buffer of fetch tags filled in order by imem responses
// Entries are allocated at tail, filled at the fill pointer, popped at head; filled entries form a prefix.
module fetch_tag_queue
   import fetch_pkg::*;
#(
   parameter int PC_SIZE    = PC_W,
   parameter int INST_WIDTH = INST_W,
   parameter int DEPTH      = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  alloc,
   input  logic [PC_SIZE-1:0]    alloc_pc,
   input  logic                  fill,
   input  logic [INST_WIDTH-1:0] fill_inst,
   input  logic                  pop,
   output logic                  head_filled,
   output logic [PC_SIZE-1:0]    head_pc,
   output logic [INST_WIDTH-1:0] head_inst,
   output logic [CW-1:0]         alloc_cnt,
   output logic [CW-1:0]         unfilled_cnt
);
   logic [PW-1:0]         head_ptr, tail_ptr, fill_ptr;
   logic [CW-1:0]         cnt, filled_cnt;
   logic [PC_SIZE-1:0]    pc_mem   [DEPTH];
   logic [INST_WIDTH-1:0] inst_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         head_ptr   <= '0;
         tail_ptr   <= '0;
         fill_ptr   <= '0;
         cnt        <= '0;
         filled_cnt <= '0;
      end else begin
         if (alloc) tail_ptr <= tail_ptr + 1'b1;
         if (fill)  fill_ptr <= fill_ptr + 1'b1;
         if (pop)   head_ptr <= head_ptr + 1'b1;
         cnt        <= cnt + CW'(alloc) - CW'(pop);
         filled_cnt <= filled_cnt + CW'(fill) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (alloc) pc_mem[tail_ptr]   <= alloc_pc;
      if (fill)  inst_mem[fill_ptr] <= fill_inst;
   end

   assign head_filled  = (filled_cnt != '0);
   assign head_pc      = (cnt != '0) ? pc_mem[head_ptr] : '0;
   assign head_inst    = head_filled ? inst_mem[head_ptr] : '0;
   assign alloc_cnt    = cnt;
   assign unfilled_cnt = cnt - filled_cnt;
endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - in-order instruction fetch queue with redirect flush
// Build option FETCH_HALT_EN: all-ones PC acts as an end-of-program sentinel that sets halted.
module inst_fetch_queue
   import fetch_pkg::*;
#(
   parameter int PC_SIZE    = PC_W,
   parameter int INST_WIDTH = INST_W,
   parameter int DEPTH      = 4
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pc_valid,
   input  logic [PC_SIZE-1:0]    pc,
   output logic                  pc_ready,
   input  logic                  redirect,
   output logic                  mem_req_valid,
   output logic [PC_SIZE-1:0]    mem_req_addr,
   input  logic                  mem_req_ready,
   input  logic                  mem_resp_valid,
   input  logic [INST_WIDTH-1:0] mem_resp_data,
   output logic                  dec_valid,
   output logic [PC_SIZE-1:0]    dec_pc,
   output logic [INST_WIDTH-1:0] dec_inst,
   input  logic                  dec_ready,
   output logic                  halted
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [CW-1:0]         alloc_cnt, unfilled_cnt, drop_cnt;
   logic [CW:0]           credit_used;
   logic                  head_filled, can_issue, is_halt, accept, resp_drop, resp_fill, pop, halt_q;
   logic [PC_SIZE-1:0]    head_pc;
   logic [INST_WIDTH-1:0] head_inst;

   // Credit covers both live entries and responses still owed to a flushed path.
   assign credit_used = {1'b0, alloc_cnt} + {1'b0, drop_cnt};
   assign can_issue   = (credit_used < (CW+1)'(DEPTH)) && !redirect && !halt_q && !reset;

`ifdef FETCH_HALT_EN
   assign is_halt = &pc;
`else
   assign is_halt = 1'b0;
`endif

   assign mem_req_valid = pc_valid && can_issue && !is_halt;
   assign mem_req_addr  = pc;
   assign pc_ready      = can_issue && (mem_req_ready || is_halt);
   assign accept        = pc_valid && pc_ready;

   assign resp_drop = mem_resp_valid && (drop_cnt != '0);
   assign resp_fill = mem_resp_valid && (drop_cnt == '0) && !redirect;
   assign dec_valid = head_filled && !redirect;
   assign pop       = dec_valid && dec_ready;

   fetch_tag_queue #(
      .PC_SIZE    (PC_SIZE),
      .INST_WIDTH (INST_WIDTH),
      .DEPTH      (DEPTH)
   ) u_tag_queue (
      .clk          (clk),
      .reset        (reset),
      .flush        (redirect),
      .alloc        (accept && !is_halt),
      .alloc_pc     (pc),
      .fill         (resp_fill),
      .fill_inst    (mem_resp_data),
      .pop          (pop),
      .head_filled  (head_filled),
      .head_pc      (head_pc),
      .head_inst    (head_inst),
      .alloc_cnt    (alloc_cnt),
      .unfilled_cnt (unfilled_cnt)
   );

   // A response arriving in the redirect cycle belongs to the old path whether or not drops were pending.
   always_ff @(posedge clk) begin
      if (reset)
         drop_cnt <= '0;
      else if (redirect)
         drop_cnt <= drop_cnt + unfilled_cnt - CW'(mem_resp_valid);
      else if (resp_drop)
         drop_cnt <= drop_cnt - 1'b1;
   end

`ifdef FETCH_HALT_EN
   always_ff @(posedge clk) begin
      if (reset || redirect)
         halt_q <= 1'b0;
      else if (accept && is_halt)
         halt_q <= 1'b1;
   end
`else
   assign halt_q = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset && mem_resp_valid)
         assert (drop_cnt != '0 || unfilled_cnt != '0);
   end

   assign dec_pc   = head_pc;
   assign dec_inst = head_inst;
   assign halted   = halt_q;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - self-checking bench for inst_fetch_queue against a queue-level model
`timescale 1ns/1ps
module tb_inst_fetch_queue;
   import fetch_pkg::*;
   localparam int DEPTH = 4;
`ifdef FETCH_HALT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   logic        clk = 1'b0, reset = 1'b1, pc_valid = 1'b0, redirect = 1'b0;
   logic        mem_req_ready = 1'b1, mem_resp_valid = 1'b0, dec_ready = 1'b0;
   logic [31:0] pc = '0, mem_resp_data = '0;
   logic        pc_ready, mem_req_valid, dec_valid, halted;
   logic [31:0] mem_req_addr, dec_pc, dec_inst;

   always #5 clk = ~clk;

   inst_fetch_queue #(.PC_SIZE(32), .INST_WIDTH(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .pc_valid(pc_valid), .pc(pc), .pc_ready(pc_ready),
      .redirect(redirect), .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
      .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_inst(dec_inst), .dec_ready(dec_ready),
      .halted(halted)
   );

   int n_cmp = 0, n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   // ---------------- environment state ----------------
   int          cyc = 0, lat = 1, n_resp = 0, n_issued = 0, issue_cyc_100 = -1;
   logic [31:0] im_addr[$];
   int          im_due[$];
   logic [31:0] beat_pc[$], beat_inst[$];
   int          beat_cyc[$];

   // ---------------- model state ----------------
   fetch_entry_t mq[$];
   int           m_drop = 0;
   bit           m_halt = 1'b0;

   logic        s_reset, s_pc_valid, s_redirect, s_req_ready, s_resp, s_dec_ready;
   logic        s_pc_ready, s_req_valid, s_dec_valid, s_halted;
   logic [31:0] s_pc, s_resp_data, s_req_addr, s_dec_pc, s_dec_inst;
   int          unf;
   bit          can, hs, e_req, e_rdy, e_dv, found;

   initial forever begin
      @(negedge clk);
      s_reset = reset;       s_pc_valid = pc_valid;   s_pc = pc;
      s_redirect = redirect; s_req_ready = mem_req_ready;
      s_resp = mem_resp_valid; s_resp_data = mem_resp_data; s_dec_ready = dec_ready;
      s_pc_ready = pc_ready; s_req_valid = mem_req_valid; s_req_addr = mem_req_addr;
      s_dec_valid = dec_valid; s_dec_pc = dec_pc; s_dec_inst = dec_inst; s_halted = halted;

      unf = 0;
      foreach (mq[i]) if (!mq[i].filled) unf++;
      can   = (mq.size() + m_drop < DEPTH) && !s_redirect && !m_halt && !s_reset;
      hs    = HALT_EN && (s_pc == 32'hFFFF_FFFF);
      e_req = s_pc_valid && can && !hs;
      e_rdy = can && (s_req_ready || hs);
      e_dv  = (mq.size() > 0) && mq[0].filled && !s_redirect;

      check("pc_ready", s_pc_ready, e_rdy);
      check("mem_req_valid", s_req_valid, e_req);
      if (e_req) check("mem_req_addr", s_req_addr, s_pc);
      check("dec_valid", s_dec_valid, e_dv);
      if (e_dv) begin
         check("dec_pc", s_dec_pc, mq[0].pc);
         check("dec_inst", s_dec_inst, mq[0].inst);
      end else if (mq.size() == 0) begin
         check("dec_pc_empty", s_dec_pc, 32'h0);
         check("dec_inst_empty", s_dec_inst, 32'h0);
      end
      check("halted", s_halted, m_halt);

      if (s_req_valid && s_req_ready) begin
         n_issued++;
         if (s_req_addr == 32'h100 && issue_cyc_100 < 0) issue_cyc_100 = cyc;
      end
      if (s_dec_valid && s_dec_ready) begin
         beat_pc.push_back(s_dec_pc);
         beat_inst.push_back(s_dec_inst);
         beat_cyc.push_back(cyc);
      end

      @(posedge clk);
      #1;
      cyc++;
      if (s_reset) begin
         mq.delete();
         m_drop = 0;
         m_halt = 1'b0;
      end else if (s_redirect) begin
         if (s_resp) check("resp_owner_redirect", (m_drop + unf) > 0, 1'b1);
         m_drop = m_drop + unf - (s_resp ? 1 : 0);
         mq.delete();
         m_halt = 1'b0;
      end else begin
         if (s_resp) begin
            if (m_drop > 0) m_drop--;
            else begin
               found = 1'b0;
               for (int i = 0; i < mq.size(); i++) begin
                  if (!found && !mq[i].filled) begin
                     mq[i].filled = 1'b1;
                     mq[i].inst   = s_resp_data;
                     found = 1'b1;
                  end
               end
               check("resp_owner", found, 1'b1);
            end
         end
         if (e_dv && s_dec_ready) void'(mq.pop_front());
         if (s_pc_valid && e_rdy) begin
            if (hs) m_halt = 1'b1;
            else    mq.push_back('{pc: s_pc, inst: 32'h0, filled: 1'b0});
         end
      end

      // imem: fixed latency, in-order, cleared by reset
      if (s_reset) begin
         im_addr.delete();
         im_due.delete();
      end else if (s_req_valid && s_req_ready) begin
         im_addr.push_back(s_req_addr);
         im_due.push_back(cyc + lat - 1);
      end
      if (im_due.size() > 0 && im_due[0] <= cyc) begin
         mem_resp_valid = 1'b1;
         mem_resp_data  = inst_of(im_addr[0]);
         void'(im_addr.pop_front());
         void'(im_due.pop_front());
         n_resp++;
      end else begin
         mem_resp_valid = 1'b0;
         mem_resp_data  = 32'h0;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) tick();
   endtask

   task automatic offer(input logic [31:0] a);
      bit acc;
      int n;
      acc = 1'b0;
      n = 0;
      pc_valid = 1'b1;
      pc = a;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = pc_valid && pc_ready;
         tick();
         n++;
      end
      pc_valid = 1'b0;
      check("offer_accepted", acc, 1'b1);
   endtask

   int b0, b_r, i0, r0;

   initial begin
      wait_cycles(3);
      @(negedge clk);
      check("rst_dec_valid", dec_valid, 1'b0);
      check("rst_mem_req_valid", mem_req_valid, 1'b0);
      check("rst_pc_ready", pc_ready, 1'b0);
      check("rst_halted", halted, 1'b0);
      check("rst_dec_pc", dec_pc, 32'h0);
      tick();
      reset = 1'b0;
      dec_ready = 1'b1;

      // back-to-back fetch, latency 1
      offer(32'h100); offer(32'h104); offer(32'h108);
      wait_cycles(6);
      check("t1_beats", beat_pc.size(), 3);
      if (beat_pc.size() >= 3) begin
         check("t1_pc0", beat_pc[0], 32'h100);  check("t1_inst0", beat_inst[0], 32'hC0DE_0100);
         check("t1_pc1", beat_pc[1], 32'h104);  check("t1_inst1", beat_inst[1], 32'hC0DE_0104);
         check("t1_pc2", beat_pc[2], 32'h108);  check("t1_inst2", beat_inst[2], 32'hC0DE_0108);
         check("t1_latency", beat_cyc[0] - issue_cyc_100, 2);
      end

      // full queue with decode stalled
      b0 = beat_pc.size();
      i0 = n_issued;
      dec_ready = 1'b0;
      fork
         begin
            for (int k = 0; k < 6; k++) offer(32'h600 + 32'(4 * k));
         end
         begin
            wait_cycles(12);
            @(negedge clk);
            check("t2_issued_full", n_issued - i0, 4);
            check("t2_pc_ready_full", pc_ready, 1'b0);
            tick();
            dec_ready = 1'b1;
         end
      join
      wait_cycles(8);
      check("t2_issued_all", n_issued - i0, 6);
      check("t2_beats", beat_pc.size() - b0, 6);
      if (beat_pc.size() >= b0 + 6)
         for (int k = 0; k < 6; k++) begin
            check("t2_pc", beat_pc[b0 + k], 32'h600 + 32'(4 * k));
            check("t2_inst", beat_inst[b0 + k], 32'hC0DE_0600 + 32'(4 * k));
         end

      // redirect with late responses, latency 3
      lat = 3;
      r0 = n_resp;
      offer(32'h200); offer(32'h204); offer(32'h208); offer(32'h20C);
      for (int k = 0; k < 50 && (n_resp - r0) < 2; k++) tick();
      tick();
      redirect = 1'b1;
      b_r = beat_pc.size();
      tick();
      redirect = 1'b0;
      offer(32'h400);
      wait_cycles(8);
      check("t3_beats_after", beat_pc.size() - b_r, 1);
      if (beat_pc.size() > b_r) begin
         check("t3_pc", beat_pc[b_r], 32'h400);
         check("t3_inst", beat_inst[b_r], 32'hC0DE_0400);
      end

      // redirect coinciding with a response and a decode handshake
      lat = 1;
      b0 = beat_pc.size();
      offer(32'h300); offer(32'h304);
      redirect = 1'b1;
      tick();
      redirect = 1'b0;
      wait_cycles(5);
      check("t4_no_beat", beat_pc.size() - b0, 0);
      offer(32'h500);
      wait_cycles(5);
      check("t4_beats", beat_pc.size() - b0, 1);
      if (beat_pc.size() > b0) check("t4_pc", beat_pc[b0], 32'h500);

      // all-ones PC
      b0 = beat_pc.size();
      i0 = n_issued;
`ifdef FETCH_HALT_EN
      offer(32'h10);
      mem_req_ready = 1'b0;
      offer(32'hFFFF_FFFF);
      mem_req_ready = 1'b1;
      pc_valid = 1'b1;
      pc = 32'h14;
      wait_cycles(4);
      @(negedge clk);
      check("t5_halted", halted, 1'b1);
      check("t5_pc_ready_halted", pc_ready, 1'b0);
      check("t5_issued", n_issued - i0, 1);
      tick();
      pc_valid = 1'b0;
      check("t5_beats", beat_pc.size() - b0, 1);
      if (beat_pc.size() > b0) check("t5_pc", beat_pc[b0], 32'h10);
      redirect = 1'b1;
      tick();
      redirect = 1'b0;
      @(negedge clk);
      check("t5_halt_cleared", halted, 1'b0);
      tick();
      offer(32'h20);
      wait_cycles(5);
      check("t5_resume_beats", beat_pc.size() - b0, 2);
      if (beat_pc.size() > b0 + 1) check("t5_resume_pc", beat_pc[b0 + 1], 32'h20);
`else
      offer(32'hFFFF_FFFF);
      wait_cycles(5);
      check("t5_issued", n_issued - i0, 1);
      check("t5_beats", beat_pc.size() - b0, 1);
      if (beat_pc.size() > b0) begin
         check("t5_pc", beat_pc[b0], 32'hFFFF_FFFF);
         check("t5_inst", beat_inst[b0], 32'h3F21_FFFF);
      end
      check("t5_halted", halted, 1'b0);
`endif

      // reset with three fetches in flight
      lat = 3;
      dec_ready = 1'b0;
      offer(32'h700); offer(32'h704); offer(32'h708);
      reset = 1'b1;
      tick();
      @(negedge clk);
      check("t6_dec_valid", dec_valid, 1'b0);
      check("t6_mem_req_valid", mem_req_valid, 1'b0);
      check("t6_pc_ready", pc_ready, 1'b0);
      check("t6_halted", halted, 1'b0);
      check("t6_dec_pc", dec_pc, 32'h0);
      check("t6_dec_inst", dec_inst, 32'h0);
      b0 = beat_pc.size();
      r0 = n_resp;
      tick();
      reset = 1'b0;
      dec_ready = 1'b1;
      wait_cycles(8);
      check("t6_no_beats", beat_pc.size() - b0, 0);
      check("t6_no_resp", n_resp - r0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
